// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: synchronises an asynchronous slide-switch bus into clk and
// debounces each bit independently, presenting a glitch-free registered word.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   sw_raw        raw switch pins, asynchronous to clk
//   sw_stable     debounced, registered switch word
//   sw_changed    one-cycle pulse when any bit of sw_stable updates (RUN only)
//   changed_mask  bits of sw_stable that updated this cycle
//   settled       high once the power-up switch state has been captured
module sw_debounce_sync #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic [WIDTH-1:0] changed_mask,
  output logic             settled
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_pre;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             changed_q, changed_d;
  logic             settled_q, settled_d;

  // Synchroniser chain; s is the last stage, s_pre the value s takes next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= sw_raw;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s     = sync_q[SYNC_STAGES-1];
  assign s_pre = sync_q[SYNC_STAGES-2];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      stable_q   <= '0;
      mask_q     <= '0;
      changed_q  <= 1'b0;
      settled_q  <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      stable_q   <= stable_d;
      mask_q     <= mask_d;
      changed_q  <= changed_d;
      settled_q  <= settled_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Next-state: whole-word capture in INIT, per-bit debounce in RUN.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    stable_d   = stable_q;
    mask_d     = '0;
    changed_d  = 1'b0;
    settled_d  = settled_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
    end

    case (state_q)
      ST_INIT: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          cnt_d[i] = '0;
        end
        // Restart on the edge where any bit of s changes value.
        if (s_pre != s) begin
          init_cnt_d = '0;
        end else if (init_cnt_q == CNT_MAX) begin
          init_cnt_d = '0;
          stable_d   = s;
          settled_d  = 1'b1;
          state_d    = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          if (s[i] == stable_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            cnt_d[i]    = '0;
            stable_d[i] = s[i];
            mask_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        changed_d = |mask_d;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign sw_stable    = stable_q;
  assign sw_changed   = changed_q;
  assign changed_mask = mask_q;
  assign settled      = settled_q;

endmodule

// File: doc/sw_debounce_sync.md
Name: sw_debounce_sync

Overview:
Input-conditioning stage that sits directly upstream of the switch-decoding datapath (conditional inverter -> adder -> one-hot decoder) on the DE0-Nano board. It synchronises the raw asynchronous slide-switch bus into the clock domain and debounces each bit independently. It presents a glitch-free registered switch word plus change strobes, so downstream logic and LEDs never see bounce or metastable values.

Parameters:
WIDTH, 4, number of switch bits conditioned.
SYNC_STAGES, 2, flip-flop depth of the synchroniser per bit; minimum 2.
DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronised bit must differ from its stable value before the stable value updates (10 ms at 50 MHz); minimum 2.
CNT_W, 19, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock (50 MHz on board).
rst_n  input  1  asynchronous, active-low reset.
sw_raw  input  WIDTH  raw switch pins, asynchronous to clk.
sw_stable  output  WIDTH  debounced, registered switch word; drives SW[2:0] consumers downstream.
sw_changed  output  1  one-cycle pulse when any bit of sw_stable updates (RUN state only).
changed_mask  output  WIDTH  bits of sw_stable that updated this cycle; all zero when sw_changed=0.
settled  output  1  high once the initial switch state has been captured; stays high until reset.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: all synchroniser flops=0, counters=0, sw_stable=0, sw_changed=0, changed_mask=0, settled=0, FSM=INIT.
- Synchroniser: sw_raw[i] passes through SYNC_STAGES flops, giving s[i]. No other logic touches sw_raw.
- Per-bit debounce counter cnt[i]:
  - If s[i]==sw_stable[i], cnt[i] is cleared to 0.
  - Otherwise cnt[i] increments by 1.
  - When s[i]!=sw_stable[i] and cnt[i]==DEBOUNCE_CYCLES-1, then on that edge sw_stable[i]<=s[i] and cnt[i]<=0.
  - Any bounce back to the stable value before the terminal count clears cnt[i]. cnt never exceeds DEBOUNCE_CYCLES-1.
- Latency from a clean sw_raw edge to sw_stable update: SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- FSM has two states, INIT and RUN.
  - INIT:
    - A single shared counter runs while s is constant across all bits. It clears whenever any bit of s changes from the previous cycle.
    - When it reaches DEBOUNCE_CYCLES-1: sw_stable<=s (whole word), settled<=1, next state RUN. No sw_changed pulse is generated.
    - Per-bit counters are held at 0 in INIT.
  - RUN:
    - Per-bit debounce as above.
    - sw_changed and changed_mask are registered and asserted in the same cycle the new sw_stable value first appears. They deassert the following cycle unless another update occurs.
    - RUN persists until reset.
- Simultaneous events: several bits reaching terminal count on the same edge update together. changed_mask carries every such bit and produces a single sw_changed pulse.
- A bit that bounces while another bit is counting does not affect the other bit's counter.
- Reset mid-count: all state is discarded, the FSM returns to INIT, and the power-up capture repeats. No pulse is generated on exit from reset.
- Outputs are driven only from flops; no combinational path from sw_raw to any output.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, SYNC_STAGES=2, WIDTH=4.
1. Power-up capture: hold sw_raw=4'b0101 through reset release -> settled rises and sw_stable=4'b0101 at cycle 2+8 after release; sw_changed never pulses.
2. Clean edge: in RUN with sw_stable=0, set sw_raw[2]=1 -> sw_stable=4'b0100 exactly 10 cycles later; sw_changed=1 and changed_mask=4'b0100 for exactly one cycle.
3. Bounce rejection: toggle sw_raw[0] high for 5 cycles, low for 2, then high steady -> no update during the bounce; sw_stable[0]=1 appears 10 cycles after the final rising edge.
4. Simultaneous: raise sw_raw[1] and sw_raw[3] on the same cycle -> single sw_changed pulse with changed_mask=4'b1010.
5. Sub-threshold glitch: a 7-cycle high pulse on sw_raw[3] -> sw_stable is unchanged and sw_changed stays 0 throughout.
6. Reset mid-count: assert rst_n=0 at count 5 of a pending change -> all outputs are 0 immediately (asynchronously); after release, INIT recaptures the current switch state with no change pulse.
